// File: rtl/tdm_mux_pkg.sv
// Definitions shared by the TDM mux and the matching 1-to-8 demultiplexer:
// channel count, select width, the channel-select type and the beat parity helper.
package tdm_mux_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0] ch_sel_t;

  // Even parity over a beat: XOR of the select bits and every data bit.
  function automatic logic beat_parity(input ch_sel_t sel, input logic [7:0] data);
    beat_parity = (^sel) ^ (^data);
  endfunction

endpackage

// File: rtl/tdm_mux_8_1_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr upward (mod 8)
// and grants the first requesting lane, gated by en.
module rr_arbiter_8
  import tdm_mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  ch_sel_t           ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output ch_sel_t           gnt_idx
);

  ch_sel_t idx_s;
  logic    found_s;

  // Priority search starting at ptr; the first hit wins.
  always_comb begin
    gnt     = {NUM_CH{1'b0}};
    gnt_idx = {SEL_W{1'b0}};
    found_s = 1'b0;
    idx_s   = ptr;
    for (int k = 0; k < NUM_CH; k++) begin
      idx_s = ptr + ch_sel_t'(k);
      if (en && req[idx_s] && !found_s) begin
        gnt[idx_s] = 1'b1;
        gnt_idx    = idx_s;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/tdm_mux_8_1.sv
// Eight-lane round-robin TDM multiplexer with a single registered output stage.
// Define TDM_MUX_PARITY_EN to add the registered out_parity output.
module tdm_mux_8_1
  import tdm_mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
`ifdef TDM_MUX_PARITY_EN
  output logic                    out_parity,
`endif
  output logic [SEL_W-1:0]        out_sel
);

  logic               load_s;
  logic [NUM_CH-1:0]  gnt_s;
  ch_sel_t            gnt_idx_s;
  logic               take_s;
  logic [WIDTH-1:0]   lane_data_s;

  ch_sel_t            ptr_q,   ptr_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  ch_sel_t            sel_q,   sel_d;

  assign load_s = ~valid_q | out_ready;

  rr_arbiter_8 u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .en      (load_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign in_ready    = gnt_s;
  assign take_s      = |gnt_s;
  assign lane_data_s = in_data[gnt_idx_s*WIDTH +: WIDTH];

  // Next state: refill on a grant, empty on a bare drain, otherwise hold.
  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (take_s) begin
      ptr_d   = gnt_idx_s + 3'd1;
      valid_d = 1'b1;
      data_d  = lane_data_s;
      sel_d   = gnt_idx_s;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= 3'd0;
      valid_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
      sel_q   <= 3'd0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

`ifdef TDM_MUX_PARITY_EN
  logic parity_q;

  // Parity travels with the beat and is updated only when the beat is refilled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (take_s) begin
      parity_q <= beat_parity(gnt_idx_s, lane_data_s[7:0]);
    end else begin
      parity_q <= parity_q;
    end
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_tdm_mux_8_1.sv
// Scoreboard bench for tdm_mux_8_1: grants are predicted by hand in the stimulus,
// and a separate monitor checks each beat as it leaves the output.
module tb_tdm_mux_8_1;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_valid;
  logic [63:0] in_data;
  logic [7:0]  in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_sel;
`ifdef TDM_MUX_PARITY_EN
  logic        out_parity;
`endif

  int total;
  int bad;

  logic [7:0]  lane_d [8];
  logic [10:0] sb_q [$];

  tdm_mux_8_1 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
`ifdef TDM_MUX_PARITY_EN
    .out_parity (out_parity),
`endif
    .out_sel    (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer must match the oldest predicted beat.
  logic [10:0] mon_e;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_beat", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("beat_sel", {29'd0, out_sel}, {29'd0, mon_e[10:8]});
        chk("beat_data", {24'd0, out_data}, {24'd0, mon_e[7:0]});
`ifdef TDM_MUX_PARITY_EN
        chk("beat_parity", {31'd0, out_parity}, {31'd0, ^mon_e});
`endif
      end
    end
  end

  // One cycle: apply inputs, check in_ready, predict the accepted beat.
  task automatic step(input logic [7:0] v, input logic r, input logic [7:0] exp_rdy);
    in_valid  = v;
    out_ready = r;
    @(negedge clk);
    chk("in_ready", {24'd0, in_ready}, {24'd0, exp_rdy});
    for (int i = 0; i < 8; i++) begin
      if (exp_rdy[i]) sb_q.push_back({i[2:0], lane_d[i]});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    lane_d[0] = 8'h3C; lane_d[1] = 8'hA5; lane_d[2] = 8'h5A; lane_d[3] = 8'hC3;
    lane_d[4] = 8'h0F; lane_d[5] = 8'hF0; lane_d[6] = 8'h96; lane_d[7] = 8'h69;
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = lane_d[i];
    rst_n     = 1'b0;
    in_valid  = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sel", {29'd0, out_sel}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All lanes valid: 0..7,0,1 one beat per cycle.
    for (int i = 0; i < 10; i++) step(8'hFF, 1'b1, 8'h01 << (i % 8));
    step(8'h00, 1'b1, 8'h00);
    chk("drained_valid", {31'd0, out_valid}, 32'd0);

    // Lanes 5 and 2 (ptr now 2): 2,5,2.
    step(8'h24, 1'b1, 8'h04);
    step(8'h24, 1'b1, 8'h20);
    step(8'h24, 1'b1, 8'h04);
    step(8'h00, 1'b1, 8'h00);

    // Lane 3 beat stalled four cycles while lane 4 waits.
    step(8'h08, 1'b0, 8'h08);
    for (int i = 0; i < 4; i++) begin
      step(8'h10, 1'b0, 8'h00);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_sel", {29'd0, out_sel}, 32'd3);
      chk("stall_data", {24'd0, out_data}, {24'd0, lane_d[3]});
    end
    step(8'h10, 1'b1, 8'h10);
    chk("refill_valid", {31'd0, out_valid}, 32'd1);
    chk("refill_sel", {29'd0, out_sel}, 32'd4);
    step(8'h00, 1'b1, 8'h00);

    // Lane 7 alone, then wrap: lane 0 before lane 7.
    step(8'h80, 1'b1, 8'h80);
    step(8'h80, 1'b1, 8'h80);
    step(8'h80, 1'b1, 8'h80);
    step(8'h81, 1'b1, 8'h01);
    step(8'h81, 1'b1, 8'h80);

    // Lane 1 carries 8'hA5.
    step(8'h02, 1'b1, 8'h02);
    chk("lane1_sel", {29'd0, out_sel}, 32'd1);
`ifdef TDM_MUX_PARITY_EN
    chk("lane1_parity", {31'd0, out_parity}, 32'd1);
`endif
    step(8'h00, 1'b1, 8'h00);

    // Async reset while a lane 6 beat is held.
    step(8'h40, 1'b0, 8'h40);
    in_valid = 8'h00;
    chk("pre_rst_sel", {29'd0, out_sel}, 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_sel", {29'd0, out_sel}, 32'd0);
    chk("arst_data", {24'd0, out_data}, 32'd0);
`ifdef TDM_MUX_PARITY_EN
    chk("arst_parity", {31'd0, out_parity}, 32'd0);
`endif
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(8'hFF, 1'b1, 8'h01);
    step(8'h00, 1'b1, 8'h00);
    chk("sb_left", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_mux_8_1.md
# tdm_mux_8_1

Eight-channel round-robin multiplexer that merges eight independent valid/ready input lanes onto one registered output stream. Each output beat carries the 3-bit channel select it came from, so a downstream 1-to-8 demultiplexer can route it back using the same select encoding (channel 0 = 3'b000 … channel 7 = 3'b111). It sits at the collection end of the channel-select datapath, ahead of the shared link.

## Interface
- WIDTH, 8: data bits per lane.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  8  per-lane valid; bit i belongs to channel i.
- in_data  input  8*WIDTH  packed lane data; channel i at bits [i*WIDTH +: WIDTH].
- in_ready  output  8  per-lane accept; at most one bit high per cycle.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accept.
- out_data  output  WIDTH  beat data.
- out_sel  output  3  source channel of the beat.
- out_parity  output  1  present only with TDM_MUX_PARITY_EN.

## Operation
- Transfer on a lane: in_valid[i] & in_ready[i] at a rising edge. Output transfer: out_valid & out_ready.
- load = !out_valid | out_ready. The output register is refilled only when load is high.
- Arbiter: round-robin pointer ptr (3 bits, reset 0). Grant = first i in order ptr, ptr+1, …, ptr+7 (mod 8) with in_valid[i]=1.
- in_ready[i] = load & grant[i]. in_ready is combinational from in_valid, out_valid, out_ready, and ptr. It is all-zero when no lane is valid or load=0.
- On a lane transfer from channel g:
  - out_data ← lane g data.
  - out_sel ← g.
  - out_valid ← 1.
  - ptr ← (g+1) mod 8, wrapping 7→0.
- On an output transfer with no lane transfer: out_valid ← 0. out_data and out_sel hold their last values.
- With load=0 (stalled), ptr and all output fields hold. A pending out_valid is never dropped or overwritten.
- Simultaneous output drain and new grant in one cycle: the register refills, out_valid stays 1. Sustained throughput is one beat per cycle.
- No lane can be granted twice in a row while any other lane is valid.
- Lanes may drop in_valid without a transfer. The grant is recomputed every cycle and is not sticky.
- Reset (async, mid-operation included) clears:
  - out_valid=0, out_data=0, out_sel=0, ptr=0, out_parity=0.
  - An in-flight beat is discarded.

## Timing
- Latency is one cycle: a lane accepted at edge k appears on out_valid/out_data/out_sel after edge k.
- There is no combinational path from in_data to the outputs. out_* are driven directly from flops.
- The only combinational paths are in_valid/out_ready → in_ready.
- Reset deassertion is synchronised externally. The block tolerates any rst_n edge.

## Configuration
- TDM_MUX_PARITY_EN defined:
  - out_parity port exists.
  - Registered with the beat as even parity over {out_sel, out_data}, i.e. XOR of all bits.
  - Reset value 0. Holds with the beat like the other output fields.
- Undefined: the out_parity port is absent and there is no parity logic. All other behaviour is identical.

## Structure
- Shared package tdm_mux_pkg holds:
  - NUM_CH = 8 and SEL_W = 3.
  - The channel-select type shared with the demultiplexer side.
- Sub-module rr_arbiter_8 contains:
  - Inputs: req[7:0], ptr[2:0], en.
  - Outputs: one-hot gnt[7:0] and encoded gnt_idx[2:0].
  - Purely combinational; ptr is registered in the parent.

## Test plan
- Reset, then all in_valid=8'hFF with out_ready=1 held → out_sel sequence 0,1,…,7,0,1 one beat per cycle. Each out_data equals its lane's data.
- ptr=0, only lanes 5 and 2 valid, out_ready=1 → out_sel 2 then 5 then 2. in_ready is one-hot each cycle.
- Beat from lane 3 pending, out_ready=0 for 4 cycles, lane 4 valid → in_ready=0. out_data/out_sel stay at the lane 3 values. On out_ready=1, lane 4 is accepted in the same cycle and out_valid stays 1.
- Single lane 7 valid continuously → out_sel=7 every cycle and ptr wraps to 0. Then lanes 0 and 7 both valid → lane 0 is granted first.
- Assert rst_n=0 asynchronously while out_valid=1 and out_sel=6 → out_valid, out_data, and out_sel are 0 immediately. After release, the first grant starts from channel 0.
- With TDM_MUX_PARITY_EN, lane 1 data 8'hA5 → out_sel=1, out_parity = XOR(3'b001, 8'hA5) = 1.
